// File: rtl/piso_stream.sv
// piso_stream: parallel-in / serial-out serializer with a valid/ready input
// handshake, a one-word holding buffer and gapless back-to-back framing.
// Every accepted word is sent as exactly WIDTH bits, whatever its content.
//
// Parameters
//   WIDTH      bits per word (2..64)
//   MSB_FIRST  0: i_din[0] leaves first, 1: i_din[WIDTH-1] leaves first
//   IDLE_LEVEL level driven on o_dout while no word is being sent
//   CNT_W      width of the saturating frames-sent counter
// Ports
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_din          parallel word, captured on accept
//   i_din_valid    source offers a word
//   o_din_ready    holding buffer empty and not in reset
//   o_dout         registered serial bit
//   o_dout_valid   o_dout carries a data bit
//   o_frame_start  high together with the first bit of every word
//   o_busy         shifter active or holding buffer occupied
//   o_frames_sent  words completely shifted out, saturating
module piso_stream #(
   parameter int WIDTH      = 10,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter int CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_din_valid,
   output logic             o_din_ready,
   output logic             o_dout,
   output logic             o_dout_valid,
   output logic             o_frame_start,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_frames_sent
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_hold_data;
   logic             r_hold_full;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_cnt;
   logic             r_dout;
   logic             r_dout_valid;
   logic             r_frame_start;
   logic [CNT_W-1:0] r_frames_sent;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_hold_data_nxt;
   logic             w_hold_full_nxt;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_dout_nxt;
   logic             w_dout_valid_nxt;
   logic             w_frame_start_nxt;
   logic [CNT_W-1:0] w_frames_nxt;
   logic             w_load;
   logic             w_accept;

   // Bit that leaves the word first in the selected bit order.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) first_bit = w[WIDTH-1];
      else           first_bit = w[0];
   endfunction

   // Word with its first bit consumed, so the next bit moves into first place.
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) advance = {w[WIDTH-2:0], 1'b0};
      else           advance = {1'b0, w[WIDTH-1:1]};
   endfunction

   // Ready only looks at state and reset, never at i_din_valid.
   assign o_din_ready   = ~r_hold_full & ~i_reset;
   assign w_accept      = i_din_valid & o_din_ready;
   assign o_busy        = (r_state == ST_SHIFT) | r_hold_full;
   assign o_dout        = r_dout;
   assign o_dout_valid  = r_dout_valid;
   assign o_frame_start = r_frame_start;
   assign o_frames_sent = r_frames_sent;

   // Next-state and next-output logic for the shifter and holding buffer.
   always_comb begin
      w_state_nxt       = r_state;
      w_hold_data_nxt   = r_hold_data;
      w_hold_full_nxt   = r_hold_full;
      w_shift_nxt       = r_shift;
      w_cnt_nxt         = r_cnt;
      w_dout_nxt        = r_dout;
      w_dout_valid_nxt  = r_dout_valid;
      w_frame_start_nxt = 1'b0;
      w_frames_nxt      = r_frames_sent;
      w_load            = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (r_hold_full) begin
               w_load = 1'b1;
            end else begin
               w_dout_nxt       = IDLE_LEVEL;
               w_dout_valid_nxt = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (r_cnt != {CW{1'b0}}) begin
               w_dout_nxt  = first_bit(r_shift);
               w_shift_nxt = advance(r_shift);
               w_cnt_nxt   = r_cnt - CW'(1);
            end else begin
               // Last bit is on the line now: count the word as sent.
               if (r_frames_sent != {CNT_W{1'b1}}) begin
                  w_frames_nxt = r_frames_sent + CNT_W'(1);
               end else begin
                  w_frames_nxt = r_frames_sent;
               end
               // A waiting word follows with no idle gap.
               if (r_hold_full) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt      = ST_IDLE;
                  w_dout_nxt       = IDLE_LEVEL;
                  w_dout_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt      = ST_IDLE;
            w_dout_nxt       = IDLE_LEVEL;
            w_dout_valid_nxt = 1'b0;
         end
      endcase

      // Move the held word into the shifter and put its first bit out.
      if (w_load) begin
         w_state_nxt       = ST_SHIFT;
         w_shift_nxt       = advance(r_hold_data);
         w_dout_nxt        = first_bit(r_hold_data);
         w_dout_valid_nxt  = 1'b1;
         w_frame_start_nxt = 1'b1;
         w_cnt_nxt         = CW'(WIDTH - 1);
         w_hold_full_nxt   = 1'b0;
      end else begin
         w_hold_full_nxt   = r_hold_full;
      end

      // Accept and load never coincide: ready is low whenever hold is full.
      if (w_accept) begin
         w_hold_data_nxt = i_din;
         w_hold_full_nxt = 1'b1;
      end else begin
         w_hold_data_nxt = r_hold_data;
      end
   end

   // State register with synchronous reset; a partial word is discarded.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_hold_data   <= {WIDTH{1'b0}};
         r_hold_full   <= 1'b0;
         r_shift       <= {WIDTH{1'b0}};
         r_cnt         <= {CW{1'b0}};
         r_dout        <= IDLE_LEVEL;
         r_dout_valid  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frames_sent <= {CNT_W{1'b0}};
      end else begin
         r_state       <= w_state_nxt;
         r_hold_data   <= w_hold_data_nxt;
         r_hold_full   <= w_hold_full_nxt;
         r_shift       <= w_shift_nxt;
         r_cnt         <= w_cnt_nxt;
         r_dout        <= w_dout_nxt;
         r_dout_valid  <= w_dout_valid_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_frames_sent <= w_frames_nxt;
      end
   end

endmodule

// File: tb/tb_piso_stream.sv
// tb_piso_stream: self-checking bench for piso_stream.
// Instance A: WIDTH=10, LSB first, idle 0, 16-bit counter.
// Instance C: same as A (shares A's inputs) but with a 2-bit counter.
// Instance B: WIDTH=8, MSB first, idle 1.
// A reference model keeps the accepted words as a schedule of start times
// and derives line activity, ready, busy and the sent count from it.
module tb_piso_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_reset = 1'b1, a_valid = 1'b0;
   logic [9:0] a_din = 10'd0;
   logic       b_reset = 1'b1, b_valid = 1'b0;
   logic [7:0] b_din = 8'd0;

   logic a_rdy, a_dout, a_vld, a_fs, a_busy;
   logic c_rdy, c_dout, c_vld, c_fs, c_busy;
   logic b_rdy, b_dout, b_vld, b_fs, b_busy;
   logic [15:0] a_fr, b_fr;
   logic [1:0]  c_fr;

   piso_stream #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .CNT_W(16)) dut_a (
      .i_clk(clk), .i_reset(a_reset), .i_din(a_din), .i_din_valid(a_valid),
      .o_din_ready(a_rdy), .o_dout(a_dout), .o_dout_valid(a_vld),
      .o_frame_start(a_fs), .o_busy(a_busy), .o_frames_sent(a_fr));

   piso_stream #(.WIDTH(10), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .CNT_W(2)) dut_c (
      .i_clk(clk), .i_reset(a_reset), .i_din(a_din), .i_din_valid(a_valid),
      .o_din_ready(c_rdy), .o_dout(c_dout), .o_dout_valid(c_vld),
      .o_frame_start(c_fs), .o_busy(c_busy), .o_frames_sent(c_fr));

   piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1), .CNT_W(16)) dut_b (
      .i_clk(clk), .i_reset(b_reset), .i_din(b_din), .i_din_valid(b_valid),
      .o_din_ready(b_rdy), .o_dout(b_dout), .o_dout_valid(b_vld),
      .o_frame_start(b_fs), .o_busy(b_busy), .o_frames_sent(b_fr));

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int          sel = 0;        // 0: instances A/C, 1: instance B
   int          m_w = 10;
   logic        m_msb = 1'b0;
   logic        m_idle = 1'b0;
   int          e = 0;          // index of the last clock edge
   int          done = 0;       // words completely sent since reset
   int          q_start[$];     // edge after which the word's first bit shows
   logic [63:0] q_data[$];
   logic        m_acc;

   // per-step observed and expected values: {dout, valid, frame_start, busy, ready}
   logic [4:0]  obs_sig, exp_sig;
   logic [22:0] obs_ext, exp_ext; // {C signals, C count, own count}

   task automatic step(input logic v, input logic [63:0] d, input logic rst);
      logic pre_rdy;
      int   idx, last_end, st;
      if (sel == 0) begin a_valid = v; a_din = d[9:0]; a_reset = rst; end
      else          begin b_valid = v; b_din = d[7:0]; b_reset = rst; end
      pre_rdy = !rst && !(q_start.size() > 0 && q_start[q_start.size()-1] > e);
      m_acc = v && pre_rdy;
      @(posedge clk);
      e++;
      if (rst) begin
         q_start.delete(); q_data.delete(); done = 0;
      end else begin
         if (m_acc) begin
            last_end = (q_start.size() > 0) ? q_start[q_start.size()-1] + m_w : 0;
            st = (e + 1 > last_end) ? e + 1 : last_end;
            q_start.push_back(st); q_data.push_back(d);
         end
         if (q_start.size() > 0 && q_start[0] + m_w == e) begin
            void'(q_start.pop_front()); void'(q_data.pop_front()); done++;
         end
      end
      if (q_start.size() > 0 && q_start[0] <= e) begin
         idx = e - q_start[0];
         exp_sig[4] = m_msb ? q_data[0][m_w-1-idx] : q_data[0][idx];
         exp_sig[3] = 1'b1;
         exp_sig[2] = (idx == 0);
      end else begin
         exp_sig[4:2] = {m_idle, 1'b0, 1'b0};
      end
      exp_sig[1] = (q_start.size() > 0);
      exp_sig[0] = !rst && !(q_start.size() > 0 && q_start[q_start.size()-1] > e);
      exp_ext[15:0]  = (done > 65535) ? 16'hFFFF : 16'(done);
      #1;
      if (sel == 0) begin
         obs_sig = {a_dout, a_vld, a_fs, a_busy, a_rdy};
         exp_ext[22:16] = {exp_sig, (done > 3) ? 2'd3 : 2'(done)};
         obs_ext = {c_dout, c_vld, c_fs, c_busy, c_rdy, c_fr, a_fr};
      end else begin
         obs_sig = {b_dout, b_vld, b_fs, b_busy, b_rdy};
         exp_ext[22:16] = 7'd0;
         obs_ext = {7'd0, b_fr};
      end
   endtask

   task automatic test_reset();
      sel = 0; m_w = 10; m_msb = 1'b0; m_idle = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 64'd0, (i < 2));
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL reset_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL reset_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
      end
      n_cmp++; if ({a_dout, a_vld, a_rdy, a_fr} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
         n_bad++; $display("FAIL reset_const: got %b%b%b %0d want 001 0", a_dout, a_vld, a_rdy, a_fr); end
   endtask

   task automatic test_single_word();
      logic [9:0] seq = 10'b1010100101;
      step(1'b1, 64'h2A5, 1'b0);
      for (int i = 0; i < 11; i++) begin
         step(1'b0, 64'd0, 1'b0);
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL single_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL single_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
         if (i < 10) begin
            n_cmp++; if ({a_dout, a_vld, a_fs} !== {seq[i], 1'b1, (i == 0)}) begin
               n_bad++; $display("FAIL single_bit%0d: got %b%b%b want %b1%b", i, a_dout, a_vld, a_fs, seq[i], (i == 0)); end
         end else begin
            n_cmp++; if ({a_dout, a_vld, a_fr} !== {1'b0, 1'b0, 16'd1}) begin
               n_bad++; $display("FAIL single_end: got %b%b %0d want 00 1", a_dout, a_vld, a_fr); end
         end
      end
   endtask

   task automatic test_all_zero();
      int vcnt = 0;
      logic [15:0] fr0 = a_fr;
      step(1'b1, 64'd0, 1'b0);
      for (int i = 0; i < 13; i++) begin
         step(1'b0, 64'd0, 1'b0);
         if (a_vld) vcnt++;
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL zero_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL zero_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
      end
      n_cmp++; if (vcnt != 10) begin n_bad++; $display("FAIL zero_len: got %0d want 10", vcnt); end
      n_cmp++; if (a_fr !== fr0 + 16'd1) begin n_bad++; $display("FAIL zero_frames: got %0d want %0d", a_fr, fr0 + 16'd1); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] words [3] = '{10'h3FF, 10'h001, 10'h155};
      int widx = 0, vrun = 0, vmax = 0, lowrun = 0, lowmax = 0, fs_n = 0;
      int fs_pos [3] = '{0, 0, 0};
      for (int i = 0; i < 45; i++) begin
         step(widx < 3, (widx < 3) ? 64'(words[widx]) : 64'd0, 1'b0);
         if (m_acc) widx++;
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL b2b_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL b2b_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
         if (a_vld) begin
            vrun++; if (vrun > vmax) vmax = vrun;
            if (a_fs && fs_n < 3) begin fs_pos[fs_n] = vrun; fs_n++; end
         end else vrun = 0;
         if (!a_rdy) begin lowrun++; if (lowrun > lowmax) lowmax = lowrun; end else lowrun = 0;
      end
      n_cmp++; if (vmax != 30) begin n_bad++; $display("FAIL b2b_run: got %0d want 30", vmax); end
      n_cmp++; if (fs_n != 3 || fs_pos[0] != 1 || fs_pos[1] != 11 || fs_pos[2] != 21) begin
         n_bad++; $display("FAIL b2b_fs: got n=%0d %0d,%0d,%0d want 1,11,21", fs_n, fs_pos[0], fs_pos[1], fs_pos[2]); end
      n_cmp++; if (lowmax > 10) begin n_bad++; $display("FAIL b2b_ready: got low run %0d want <=10", lowmax); end
   endtask

   task automatic test_reset_mid_word();
      logic [2:0] v_seq = 3'b111;
      for (int i = 0; i < 20; i++) begin
         if (i < 3)       step(v_seq[i], (i == 0) ? 64'h1C7 : 64'h2B3, 1'b0);
         else if (i == 6) step(1'b0, 64'd0, 1'b1);
         else if (i == 8) step(1'b1, 64'h0F0, 1'b0);
         else             step(1'b0, 64'd0, 1'b0);
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL rstmid_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL rstmid_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
         if (i == 6) begin
            n_cmp++; if ({a_dout, a_vld, a_busy, a_rdy, a_fr} !== {4'b0000, 16'd0}) begin
               n_bad++; $display("FAIL rstmid_clear: got %b%b%b%b %0d want 0000 0", a_dout, a_vld, a_busy, a_rdy, a_fr); end
         end
         if (i == 7) begin
            n_cmp++; if (a_rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_release: got %b want 1", a_rdy); end
         end
      end
      n_cmp++; if (a_fr !== 16'd1) begin n_bad++; $display("FAIL rstmid_frames: got %0d want 1", a_fr); end
   endtask

   task automatic test_saturation();
      logic [1:0] tbl [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      step(1'b0, 64'd0, 1'b1);
      for (int w = 0; w < 5; w++) begin
         step(1'b1, 64'($urandom_range(0, 1023)), 1'b0);
         for (int i = 0; i < 11; i++) begin
            step(1'b0, 64'd0, 1'b0);
            n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL sat_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
         end
         n_cmp++; if (c_fr !== tbl[w]) begin n_bad++; $display("FAIL sat_word%0d: got %0d want %0d", w, c_fr, tbl[w]); end
      end
   endtask

   task automatic test_random(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 59) == 0);
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL rand_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL rand_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
      end
   endtask

   task automatic test_msb_idle();
      logic [7:0] seq = 8'hC3;
      sel = 1; m_w = 8; m_msb = 1'b1; m_idle = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if (i < 2)       step(1'b0, 64'd0, 1'b1);
         else if (i == 3) step(1'b1, 64'hC3, 1'b0);
         else             step(1'b0, 64'd0, 1'b0);
         n_cmp++; if (obs_sig !== exp_sig) begin n_bad++; $display("FAIL msb_sig: got %b want %b e%0d", obs_sig, exp_sig, e); end
         n_cmp++; if (obs_ext !== exp_ext) begin n_bad++; $display("FAIL msb_cnt: got %h want %h e%0d", obs_ext, exp_ext, e); end
         if (i >= 4 && i < 12) begin
            n_cmp++; if ({b_dout, b_vld} !== {seq[11-i], 1'b1}) begin
               n_bad++; $display("FAIL msb_bit%0d: got %b%b want %b1", i - 4, b_dout, b_vld, seq[11-i]); end
         end else begin
            n_cmp++; if ({b_dout, b_vld} !== 2'b10) begin
               n_bad++; $display("FAIL msb_idle: got %b%b want 10 e%0d", b_dout, b_vld, e); end
         end
      end
      test_random(200);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_all_zero();
      test_back_to_back();
      test_reset_mid_word();
      test_saturation();
      test_random(300);
      test_msb_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a one-word holding buffer and gapless back-to-back framing. It sits between the line encoder (e.g. 8b/10b word source) and the serial transmit pin. It emits exactly WIDTH bits per accepted word regardless of data content, so all-zero words are sent in full. Bit order and idle line level are selectable.

## Interface
- WIDTH, 10, bits per word; legal range 2..64
- MSB_FIRST, 0, 0 = din[0] sent first; 1 = din[WIDTH-1] sent first
- IDLE_LEVEL, 0, value driven on dout when no word is being sent
- CNT_W, 16, width of frames_sent counter

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- din  in  WIDTH  parallel word; sampled on accept
- din_valid  in  1  source has a word on din
- din_ready  out  1  block can accept; accept = din_valid & din_ready at a rising edge
- dout  out  1  registered serial output
- dout_valid  out  1  high while dout carries a data bit
- frame_start  out  1  one-cycle pulse, high with first bit of each word
- busy  out  1  shifter active or holding buffer full
- frames_sent  out  CNT_W  count of words fully shifted out, saturating

## Operation
- Storage: holding register (hold_data, hold_full), shift register, bit counter of width $clog2(WIDTH).
- din_ready = ~hold_full & ~reset (combinational); depends only on state and reset, never on din_valid.
- Accept: hold_data <= din, hold_full <= 1. Accepts while reset is high are ignored.
- Shifter states: IDLE, SHIFT.
  - IDLE: dout = IDLE_LEVEL, dout_valid = 0. If hold_full: load shifter from hold, hold_full <= 0, go SHIFT, dout <= first bit, frame_start <= 1, counter <= WIDTH-1.
  - SHIFT, counter > 0: dout <= next bit, counter decrements, frame_start <= 0.
  - SHIFT, counter == 0 (last bit on dout this cycle): frames_sent increments (saturating at all-ones). If hold_full: reload as from IDLE (no gap, frame_start pulses). Else go IDLE, dout <= IDLE_LEVEL, dout_valid <= 0.
- Accept and hold-to-shifter transfer at the same edge cannot coincide (din_ready low while hold_full); no bypass path.
- Bit order: MSB_FIRST = 0 sends din[0]..din[WIDTH-1]; MSB_FIRST = 1 sends din[WIDTH-1]..din[0].
- Data content never terminates a word; all-zero and all-one words take WIDTH bit times.
- busy = (state == SHIFT) | hold_full.
- Reset (any cycle, including mid-word): state IDLE, hold_full 0, counter 0, dout = IDLE_LEVEL, dout_valid 0, frame_start 0, frames_sent 0; partial word discarded and not counted. din_ready low while reset is high, high the cycle after release.

## Timing
- Accept at edge k: first bit on dout, dout_valid = 1 and frame_start = 1 after edge k+1 (if shifter idle); bit i of the send order is valid after edge k+1+i; last bit after edge k+WIDTH.
- din_ready goes high again after edge k+1 (hold drained into shifter).
- Sustained throughput: one word per WIDTH cycles with zero idle cycles, provided each next word is accepted at least one cycle before the current word's last bit.
- frames_sent updates at the edge that ends the last bit (edge k+WIDTH+1).
- Late next word: if it is accepted at the edge that ends the last bit, dout shows one IDLE_LEVEL cycle, then the new frame starts.

## Test plan
- Single word, WIDTH=10, MSB_FIRST=0: din=10'h2A5 accepted at edge 3 -> dout bits 1,0,1,0,0,1,0,1,0,1 after edges 4..13; frame_start only after edge 4; dout_valid low and dout=0 after edge 14; frames_sent=1.
- All-zero word 10'h000 -> dout_valid high for exactly 10 cycles; frames_sent increments (regression for content-terminated sending).
- Back-to-back: din_valid held high with words 10'h3FF, 10'h001, 10'h155 -> 30 consecutive dout_valid cycles; frame_start pulses at cycles 1, 11, 21; din_ready never low for more than 10 consecutive cycles.
- MSB_FIRST=1, IDLE_LEVEL=1, WIDTH=8: din=8'hC3 -> dout 1,1,0,0,0,0,1,1; dout=1 while idle before and after.
- Reset mid-word: reset high after bit 4 of a word with another in hold -> next cycle dout=IDLE_LEVEL, dout_valid=0, busy=0, frames_sent=0; din_ready low during reset, high after release; new word sends cleanly.
- Saturation, CNT_W=2: send 5 words -> frames_sent reads 1,2,3,3,3.
